// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared FSM state type and select-width helper for the stream mux
package stream_mux_pkg;
    typedef enum logic {IDLE, LOCKED} state_t;
    function automatic int sel_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/stream_mux_nto1_if.sv
// stream_mux_nto1_if: N-input stream bundle with mux-side and source/sink-side modports
interface stream_mux_nto1_if import stream_mux_pkg::*; #(
    parameter int NCH = 4,
    parameter int W = 1
);
    localparam int SELW = sel_w(NCH);
    logic mode;
    logic [SELW-1:0] sel;
    logic [NCH-1:0] in_valid;
    logic [NCH-1:0][W-1:0] in_data;
    logic [NCH-1:0] in_last;
    logic [NCH-1:0] in_ready;
    logic out_valid;
    logic [W-1:0] out_data;
    logic out_last;
    logic out_ready;
    logic [SELW-1:0] grant_idx;
    modport slave (
        input mode, sel, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, grant_idx
    );
    modport master (
        output mode, sel, in_valid, in_data, in_last, out_ready,
        input in_ready, out_valid, out_data, out_last, grant_idx
    );
endinterface

// File: rtl/stream_mux_nto1_rr_pick.sv
// rr_pick: first set request after ptr, searching upward with wrap-around
module rr_pick #(
    parameter int NCH = 4,
    parameter int SELW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic found,
    output logic [SELW-1:0] idx
);
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NCH]) begin
                found = 1'b1;
                idx = SELW'((int'(ptr) + k) % NCH);
            end
        end
    end
endmodule

// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: packet-locked N:1 stream mux with select or round-robin arbitration
module stream_mux_nto1 import stream_mux_pkg::*; #(
    parameter int NCH = 4,
    parameter int W = 1
) (
    input logic clk,
    input logic rst,
    stream_mux_nto1_if.slave bus
);
    localparam int SELW = sel_w(NCH);
    state_t state, state_nx;
    logic [SELW-1:0] lock_idx, rr_ptr, grant, pick;
    logic found, grant_ok, free, take;
    rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
        .req(bus.in_valid),
        .ptr(rr_ptr),
        .found(found),
        .idx(pick)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = take ? (bus.in_last[grant] ? IDLE : LOCKED) : state;
    end
    always_comb begin
        free = !bus.out_valid || bus.out_ready;
        grant = (state == LOCKED) ? lock_idx : bus.mode ? pick : bus.sel;
        grant_ok = (state == LOCKED) ? 1'b1 : bus.mode ? found : (int'(bus.sel) < NCH);
        take = grant_ok && free && !rst && bus.in_valid[grant];
        bus.in_ready = '0;
        for (int i = 0; i < NCH; i++) bus.in_ready[i] = grant_ok && free && !rst && grant == SELW'(i);
    end
    // the output register only reloads when free, so a stalled beat holds steady
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_last <= 1'b0;
            bus.grant_idx <= '0;
            lock_idx <= '0;
            rr_ptr <= SELW'(NCH - 1);
        end else begin
            if (take && state == IDLE) lock_idx <= grant;
            if (take && bus.in_last[grant] && bus.mode) rr_ptr <= grant;
            if (free) begin
                bus.out_valid <= take;
                if (take) begin
                    bus.out_data <= bus.in_data[grant];
                    bus.out_last <= bus.in_last[grant];
                    bus.grant_idx <= grant;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb_stream_mux_nto1: directed checks of select, round-robin, lock, backpressure and reset
module tb_stream_mux_nto1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    stream_mux_nto1_if #(.NCH(4), .W(8)) ifa ();
    stream_mux_nto1_if #(.NCH(3), .W(8)) ifb ();
    stream_mux_nto1 #(.NCH(4), .W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    stream_mux_nto1 #(.NCH(3), .W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        ifa.mode = 1'b0; ifa.sel = '0; ifa.in_valid = '0; ifa.in_data = '0; ifa.in_last = '0; ifa.out_ready = 1'b1;
        ifb.mode = 1'b0; ifb.sel = '0; ifb.in_valid = '0; ifb.in_data = '0; ifb.in_last = '0; ifb.out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", ifa.in_ready, 4'b0000);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_grant", ifa.grant_idx, 0);
        rst = 1'b0;
        // select mode
        ifa.sel = 2; ifa.in_valid = 4'b0100; ifa.in_data[2] = 8'hA5; ifa.in_last = 4'b0100;
        #1 chk("sel_in_ready", ifa.in_ready, 4'b0100);
        step();
        chk("sel_valid", ifa.out_valid, 1);
        chk("sel_data", ifa.out_data, 8'hA5);
        chk("sel_grant", ifa.grant_idx, 2);
        chk("sel_last", ifa.out_last, 1);
        ifa.in_valid = '0;
        step();
        chk("sel_drain", ifa.out_valid, 0);
        // round robin, one-beat packets
        ifa.mode = 1'b1; ifa.in_valid = 4'b1111; ifa.in_last = 4'b1111;
        for (int i = 0; i < 4; i++) ifa.in_data[i] = 8'(8'h10 + i);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_grant", ifa.grant_idx, k % 4);
            chk("rr_data", ifa.out_data, 8'h10 + k % 4);
            chk("rr_valid", ifa.out_valid, 1);
        end
        ifa.in_valid = '0;
        step();
        chk("rr_drain", ifa.out_valid, 0);
        // packet lock on channel 1 while channel 0 waits and sel moves
        ifa.mode = 1'b0; ifa.sel = 1; ifa.in_valid = 4'b0011; ifa.in_last = 4'b0000;
        ifa.in_data[1] = 8'h21; ifa.in_data[0] = 8'h30;
        step();
        chk("lock_g1", ifa.grant_idx, 1);
        chk("lock_d1", ifa.out_data, 8'h21);
        ifa.sel = 0; ifa.in_data[1] = 8'h22;
        #1 chk("lock_in_ready", ifa.in_ready, 4'b0010);
        step();
        chk("lock_g2", ifa.grant_idx, 1);
        chk("lock_d2", ifa.out_data, 8'h22);
        ifa.sel = 2; ifa.in_data[1] = 8'h23; ifa.in_last = 4'b0010;
        step();
        chk("lock_g3", ifa.grant_idx, 1);
        chk("lock_d3", ifa.out_data, 8'h23);
        chk("lock_last", ifa.out_last, 1);
        ifa.sel = 0; ifa.in_valid = 4'b0001; ifa.in_last = 4'b0001;
        step();
        chk("lock_after_g", ifa.grant_idx, 0);
        chk("lock_after_d", ifa.out_data, 8'h30);
        ifa.in_valid = '0;
        step();
        // backpressure
        ifa.sel = 3; ifa.in_valid = 4'b1000; ifa.in_last = 4'b1000; ifa.in_data[3] = 8'h40; ifa.out_ready = 1'b0;
        step();
        chk("bp_first", ifa.out_data, 8'h40);
        ifa.in_data[3] = 8'h41;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", ifa.in_ready, 4'b0000);
            step();
            chk("bp_hold_data", ifa.out_data, 8'h40);
            chk("bp_hold_valid", ifa.out_valid, 1);
            chk("bp_hold_grant", ifa.grant_idx, 3);
        end
        ifa.out_ready = 1'b1;
        step();
        chk("bp_resume1", ifa.out_data, 8'h41);
        ifa.in_data[3] = 8'h42;
        step();
        chk("bp_resume2", ifa.out_data, 8'h42);
        chk("bp_resume2_v", ifa.out_valid, 1);
        ifa.in_valid = '0;
        step();
        chk("bp_drain", ifa.out_valid, 0);
        // mid-packet reset: rr_ptr is 0, so channel 2 wins and locks
        ifa.mode = 1'b1; ifa.in_valid = 4'b0100; ifa.in_last = 4'b0000; ifa.in_data[2] = 8'h55;
        step();
        chk("mpr_grant", ifa.grant_idx, 2);
        ifa.in_valid = '0; ifa.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1 chk("mpr_valid", ifa.out_valid, 0);
        chk("mpr_in_ready", ifa.in_ready, 4'b0000);
        @(posedge clk);
        #1 rst = 1'b0;
        ifa.in_valid = 4'b1111; ifa.in_last = 4'b1111; ifa.in_data[0] = 8'h10; ifa.out_ready = 1'b1;
        step();
        chk("mpr_next_grant", ifa.grant_idx, 0);
        chk("mpr_next_data", ifa.out_data, 8'h10);
        ifa.in_valid = '0;
        // invalid select on three channels
        ifb.sel = 3; ifb.in_valid = 3'b111; ifb.in_last = 3'b111; ifb.in_data[2] = 8'h77;
        #1 chk("inv_in_ready", ifb.in_ready, 3'b000);
        step();
        chk("inv_valid1", ifb.out_valid, 0);
        step();
        chk("inv_valid2", ifb.out_valid, 0);
        ifb.sel = 2;
        #1 chk("nch3_in_ready", ifb.in_ready, 3'b100);
        step();
        chk("nch3_data", ifb.out_data, 8'h77);
        chk("nch3_grant", ifb.grant_idx, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_mux_nto1.md
STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the input channel count (legal range 2..16).
REQ-002 The block SHALL have parameter W, default 1, giving the data width per channel in bits.
REQ-003 The block SHALL have derived constant SELW = max(1, clog2(NCH)), giving the select and grant index width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The ports SHALL be as follows:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  arbitration mode: 0 = select-driven, 1 = round-robin.
- sel  in  SELW  channel select, used in mode 0 only.
- in_valid  in  NCH  per-channel beat valid.
- in_data  in  NCH x W  per-channel beat data.
- in_last  in  NCH  per-channel end-of-packet flag.
- in_ready  out  NCH  per-channel accept.
- out_valid  out  1  output beat valid.
- out_data  out  W  output beat data.
- out_last  out  1  output end-of-packet flag.
- out_ready  in  1  downstream accept.
- grant_idx  out  SELW  index of the channel whose beat is held in the output register.

Function
REQ-006 A beat SHALL transfer on input channel i when in_valid[i] and in_ready[i] are both high at a rising clk edge; an output beat SHALL transfer when out_valid and out_ready are both high.
REQ-007 The output SHALL be a single register stage, so an accepted input beat appears on out_valid/out_data/out_last/grant_idx exactly one cycle later.
REQ-008 The output register SHALL be "free" when out_valid is 0 or out_ready is 1, giving full throughput of one beat per cycle.
REQ-009 At most one in_ready bit SHALL be high in any cycle.
REQ-010 in_ready[i] SHALL equal (i is the current grant) AND (output register free).
REQ-011 The FSM SHALL have two states: IDLE and LOCKED.
REQ-012 In IDLE with mode 0, the grant SHALL be sel.
REQ-013 In IDLE with mode 0, if sel >= NCH then no channel SHALL be granted and all in_ready bits SHALL be 0.
REQ-014 In IDLE with mode 1, the grant SHALL be the first channel with in_valid high, searching from (rr_ptr+1) mod NCH upward with wrap-around; with no valid channel there SHALL be no grant.
REQ-015 In IDLE, a transferred beat with in_last=0 SHALL move the FSM to LOCKED and store the granted index in lock_idx.
REQ-016 In IDLE, a transferred beat with in_last=1 SHALL leave the FSM in IDLE.
REQ-017 In LOCKED, the grant SHALL be lock_idx regardless of mode and sel changes.
REQ-018 In LOCKED, the FSM SHALL return to IDLE on the cycle a beat with in_last=1 transfers from lock_idx.
REQ-019 In LOCKED, in_valid on other channels SHALL be ignored.
REQ-020 rr_ptr SHALL update to the granted index only when a beat with in_last=1 transfers in mode 1; in mode 0 it SHALL hold.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_last and grant_idx SHALL remain stable and all in_ready bits SHALL be 0.
REQ-022 A single-channel back-to-back stream SHALL sustain 1 beat/cycle, including packets with in_last=1 on every beat.
REQ-023 A mode change while in LOCKED SHALL take effect only at the next IDLE arbitration.

Reset
REQ-024 On rst assertion the block SHALL immediately force out_valid=0, out_data=0, out_last=0, grant_idx=0, state=IDLE, lock_idx=0, rr_ptr=NCH-1 (so channel 0 wins first in mode 1).
REQ-025 Reset asserted mid-packet SHALL discard both the held output beat and the lock.
REQ-026 in_ready SHALL be all 0 while rst is high.

Structure
REQ-027 The state enum (IDLE, LOCKED) and the SELW derivation function SHALL live in shared package stream_mux_pkg.
REQ-028 The round-robin priority search SHALL be a separate combinational sub-module, rr_pick (inputs: request vector and pointer; outputs: found flag and index).
REQ-029 The datapath selection SHALL be a plain indexed select and SHALL not be a sub-module.

Verification
REQ-030 The bench SHALL cover select mode: NCH=4, W=8, mode=0, sel=2, in_data[2]=0xA5, in_last[2]=1, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, grant_idx=2, only in_ready[2] high.
REQ-031 The bench SHALL cover round-robin fairness: mode=1, all four channels continuously valid with 1-beat packets -> grant_idx sequence 0,1,2,3,0.
REQ-032 The bench SHALL cover packet lock: channel 1 sends 3 beats (last on beat 3) while channel 0 is valid and sel is toggled -> out grant_idx=1 for all 3 beats, channel 0 granted on the following beat.
REQ-033 The bench SHALL cover backpressure: out_ready held 0 for 5 cycles with out_valid=1 -> out_data stable, in_ready all 0; out_ready=1 -> one beat per cycle resumes with no loss or duplication.
REQ-034 The bench SHALL cover invalid select: NCH=3, mode=0, sel=3 -> in_ready=000 and out_valid stays 0.
REQ-035 The bench SHALL cover mid-packet reset: rst pulse during LOCKED -> out_valid=0 the same cycle, state IDLE; in mode 1 the next grant is channel 0.
